// File: rtl/image_frame_loader_pkg.sv
// Shared definitions for the MNIST pixel path: frame geometry, quantized pixel
// width, loader FSM state encodings and the 8-bit to 4-bit pixel quantizer.
// Items: FRAME_PIXELS, PIXEL_Q_W, wstate_e, rstate_e, quantize().
package image_frame_loader_pkg;

   localparam int FRAME_PIXELS = 784;   // 28x28 image
   localparam int PIXEL_Q_W    = 4;     // quantized pixel width seen by the core

   // Write side: filling the write bank, or holding a complete frame until
   // the read side can take it.
   typedef enum logic {
      W_FILL = 1'b0,
      W_FULL = 1'b1
   } wstate_e;

   // Read side: free, announcing a new frame, or owned by the core.
   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_BUSY  = 2'd2
   } rstate_e;

   // round_en = 1: round to nearest with saturation at 15.
   // round_en = 0: keep the top nibble.
   // The +8 is done 9 bits wide so 248..255 do not wrap to 0.
   function automatic logic [PIXEL_Q_W-1:0] quantize(input logic [7:0] pix,
                                                      input logic       round_en);
      logic [8:0] sum;
      logic [4:0] scaled;
      sum    = {1'b0, pix} + 9'd8;
      scaled = sum[8:4];
      if (!round_en) begin
         quantize = pix[7:4];
      end else if (scaled > 5'd15) begin
         quantize = 4'hF;
      end else begin
         quantize = scaled[3:0];
      end
   endfunction

endpackage

// File: rtl/image_frame_loader_frame_bank_ram.sv
// One frame bank: simple dual-port RAM, 1 write port, 1 registered read port.
// Latency: read data valid 1 cycle after raddr; write takes effect at clk edge.
// Backpressure: none, accepts a write and a read every cycle.
// Ports: clk, rst (clears only the read register), we/waddr/wdata, raddr/rdata.
module frame_bank_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] rdata_q;

   // Storage array carries no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = mem[raddr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/image_frame_loader.sv
// Double-buffered 784-pixel frame store in front of the MNIST core: quantizes
// an 8-bit pixel stream into the write bank while the core reads the other.
// Latency: rd_data 1 cycle after rd_addr; start 2 cycles after last pixel.
// Backpressure: s_ready drops (from registered state only) while a complete
// frame waits for the core to release the read bank.
// Ports: s_pixel/s_valid/s_last/s_ready pixel stream in; rd_addr/rd_data core
// fetch port; start/busy/net_done frame handshake; frame_err length-error pulse.
module image_frame_loader #(
   parameter int FRAME_PIXELS = 784,
   parameter int ADDR_W       = 10,
   parameter int ROUND        = 1
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [7:0]                                   s_pixel,
   input  logic                                         s_valid,
   input  logic                                         s_last,
   output logic                                         s_ready,
   input  logic [ADDR_W-1:0]                            rd_addr,
   output logic [image_frame_loader_pkg::PIXEL_Q_W-1:0] rd_data,
   output logic                                         start,
   input  logic                                         net_done,
   output logic                                         frame_err,
   output logic                                         busy
);

   import image_frame_loader_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_PIXELS - 1);
   localparam logic [ADDR_W:0]   FRAME_LEN = (ADDR_W+1)'(FRAME_PIXELS);

   wstate_e               wstate_q, wstate_d;
   rstate_e               rstate_q, rstate_d;
   logic [ADDR_W-1:0]     wcnt_q, wcnt_d;
   logic                  sel_q, sel_d;          // physical bank being written
   logic                  frame_err_q, frame_err_d;
   logic                  done_prev_q, done_prev_d;
   logic                  rsel_q, rsel_d;        // bank behind the current rd_data
   logic                  oob_q, oob_d;          // rd_addr was past the frame

   logic                  xfer;
   logic                  wr_en;
   logic                  swap;
   logic                  done_rise;
   logic [PIXEL_Q_W-1:0]  q_pix;
   logic [PIXEL_Q_W-1:0]  rdata0, rdata1;

   assign s_ready   = (wstate_q == W_FILL);
   assign xfer      = s_valid & s_ready;
   assign done_rise = net_done & ~done_prev_q;
   assign q_pix     = quantize(s_pixel, ROUND != 0);

   // ------------------------------------------------------------------
   // Write FSM
   // ------------------------------------------------------------------
   always_comb begin
      wstate_d    = wstate_q;
      wcnt_d      = wcnt_q;
      sel_d       = sel_q;
      frame_err_d = 1'b0;
      wr_en       = 1'b0;
      swap        = 1'b0;
      case (wstate_q)
         W_FILL: begin
            if (xfer) begin
               wr_en = 1'b1;
               if (s_last && (wcnt_q == LAST_IDX)) begin
                  wstate_d = W_FULL;
               end else if (s_last || (wcnt_q == LAST_IDX)) begin
                  // Length mismatch: drop the frame and refill the same bank.
                  frame_err_d = 1'b1;
                  wcnt_d      = '0;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         W_FULL: begin
            // Hand the bank over only when the core has released the other one.
            if (rstate_q == R_IDLE) begin
               swap     = 1'b1;
               sel_d    = ~sel_q;
               wcnt_d   = '0;
               wstate_d = W_FILL;
            end
         end
         default: begin
            wstate_d = W_FILL;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Read FSM
   // ------------------------------------------------------------------
   always_comb begin
      rstate_d = rstate_q;
      case (rstate_q)
         R_IDLE:  if (swap)      rstate_d = R_START;
         R_START:                rstate_d = R_BUSY;
         R_BUSY:  if (done_rise) rstate_d = R_IDLE;
         default:                rstate_d = R_IDLE;
      endcase
   end

   assign start     = (rstate_q == R_START);
   assign busy      = (rstate_q == R_BUSY);
   assign frame_err = frame_err_q;

   // ------------------------------------------------------------------
   // Read port bookkeeping: remember which bank and range applied to the
   // address sampled this cycle, so a swap does not skew the returned data.
   // ------------------------------------------------------------------
   always_comb begin
      done_prev_d = net_done;
      rsel_d      = ~sel_q;
      oob_d       = ({1'b0, rd_addr} >= FRAME_LEN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate_q    <= W_FILL;
         rstate_q    <= R_IDLE;
         wcnt_q      <= '0;
         sel_q       <= 1'b0;
         frame_err_q <= 1'b0;
         done_prev_q <= 1'b0;
         rsel_q      <= 1'b1;
         oob_q       <= 1'b0;
      end else begin
         wstate_q    <= wstate_d;
         rstate_q    <= rstate_d;
         wcnt_q      <= wcnt_d;
         sel_q       <= sel_d;
         frame_err_q <= frame_err_d;
         done_prev_q <= done_prev_d;
         rsel_q      <= rsel_d;
         oob_q       <= oob_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame banks
   // ------------------------------------------------------------------
   frame_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(PIXEL_Q_W)) u_bank0 (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en & ~sel_q),
      .waddr (wcnt_q),
      .wdata (q_pix),
      .raddr (rd_addr),
      .rdata (rdata0)
   );

   frame_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(PIXEL_Q_W)) u_bank1 (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en & sel_q),
      .waddr (wcnt_q),
      .wdata (q_pix),
      .raddr (rd_addr),
      .rdata (rdata1)
   );

   // Both inputs of this mux are registers, so rd_data keeps the 1-cycle
   // registered timing and clears with rst.
   assign rd_data = oob_q ? '0 : (rsel_q ? rdata1 : rdata0);

endmodule

// File: tb/tb_image_frame_loader.sv
module tb_image_frame_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_pixel = '0;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic [9:0] rd_addr = '0;
   logic       net_done = 1'b0;

   // r1: ROUND=1 instance, r0: ROUND=0 instance, driven identically
   logic       s_ready1, start1, frame_err1, busy1;
   logic [3:0] rd_data1;
   logic       s_ready0, start0, frame_err0, busy0;
   logic [3:0] rd_data0;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int scnt1 = 0, scnt0 = 0, ecnt1 = 0, ecnt0 = 0;
   int last_start_cyc = 0;
   int xfer_cyc = 0;

   logic [7:0] gen   [784];   // frame being streamed
   logic [7:0] shown [784];   // frame expected in the read bank

   always #5 clk = ~clk;

   image_frame_loader #(.FRAME_PIXELS(784), .ADDR_W(10), .ROUND(1)) dut_r1 (
      .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready1), .rd_addr(rd_addr), .rd_data(rd_data1), .start(start1),
      .net_done(net_done), .frame_err(frame_err1), .busy(busy1));

   image_frame_loader #(.FRAME_PIXELS(784), .ADDR_W(10), .ROUND(0)) dut_r0 (
      .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready0), .rd_addr(rd_addr), .rd_data(rd_data0), .start(start0),
      .net_done(net_done), .frame_err(frame_err0), .busy(busy0));

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (start1) begin scnt1 <= scnt1 + 1; last_start_cyc <= cyc; end
         if (start0) scnt0 <= scnt0 + 1;
         if (frame_err1) ecnt1 <= ecnt1 + 1;
         if (frame_err0) ecnt0 <= ecnt0 + 1;
      end
   end

   // Reference quantizer from the arithmetic definition
   function automatic int qref(input int p, input bit rnd);
      int v;
      if (!rnd) return p / 16;
      v = (p + 8) / 16;
      return (v > 15) ? 15 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_gen(input int mode);
      for (int i = 0; i < 784; i++)
         gen[i] = (mode == 0) ? 8'(i % 256) : 8'($urandom_range(0, 255));
   endtask

   task automatic send_frame(input int n, input int last_idx);
      int t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            s_valid = 1'b0;
            @(negedge clk);
         end
         s_pixel = gen[i];
         s_valid = 1'b1;
         s_last  = (i == last_idx);
         t = 0;
         while (!s_ready1 && t < 3000) begin
            @(negedge clk);
            t++;
         end
         if (t >= 3000) begin
            chk("s_ready_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         xfer_cyc = cyc;
         @(posedge clk);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int prev);
      int t = 0;
      while (scnt1 <= prev && t < 3000) begin
         @(posedge clk);
         t++;
      end
      chk({tag, "_start_seen"}, 32'(scnt1 > prev), 32'd1);
   endtask

   task automatic pulse_done();
      @(negedge clk);
      net_done = 1'b1;
      @(negedge clk);
      net_done = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int addr);
      int e1, e0;
      @(negedge clk);
      rd_addr = 10'(addr);
      @(negedge clk);
      e1 = (addr < 784) ? qref(int'(shown[addr]), 1'b1) : 0;
      e0 = (addr < 784) ? qref(int'(shown[addr]), 1'b0) : 0;
      chk($sformatf("%s_r1_a%0d", tag, addr), 32'(rd_data1), 32'(e1));
      chk($sformatf("%s_r0_a%0d", tag, addr), 32'(rd_data0), 32'(e0));
   endtask

   task automatic rd_lit(input string tag, input int addr, input int e1, input int e0);
      @(negedge clk);
      rd_addr = 10'(addr);
      @(negedge clk);
      chk($sformatf("%s_r1_a%0d", tag, addr), 32'(rd_data1), 32'(e1));
      chk($sformatf("%s_r0_a%0d", tag, addr), 32'(rd_data0), 32'(e0));
   endtask

   task automatic check_frame(input string tag);
      rd_chk(tag, 0);
      rd_chk(tag, 783);
      rd_chk(tag, 784 + $urandom_range(0, 239));
      for (int k = 0; k < 5; k++) rd_chk(tag, $urandom_range(0, 783));
   endtask

   // Full good frame: checks start latency, single pulse on both instances, busy
   task automatic good_frame(input string tag, input int mode);
      int s_before;
      fill_gen(mode);
      s_before = scnt1;
      send_frame(784, 783);
      wait_start(tag, s_before);
      chk({tag, "_latency"}, 32'(last_start_cyc - xfer_cyc), 32'd2);
      @(negedge clk);
      chk({tag, "_busy"}, 32'({busy1, busy0}), 32'd3);
      shown = gen;
   endtask

   initial begin
      int s_before, e_before;
      int q_in  [7] = '{0, 7, 8, 15, 16, 247, 255};
      int q_r0  [7] = '{0, 0, 0, 0, 1, 15, 15};
      int q_r1  [7] = '{0, 0, 1, 1, 1, 15, 15};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_start",  32'({start1, start0}), 32'd0);
      chk("rst_busy",   32'({busy1, busy0}), 32'd0);
      chk("rst_err",    32'({frame_err1, frame_err0}), 32'd0);
      chk("rst_rdata",  32'({rd_data1, rd_data0}), 32'd0);
      chk("rst_sready", 32'({s_ready1, s_ready0}), 32'd3);
      rst = 1'b0;

      // Single frame, ramp pattern
      good_frame("ramp", 0);
      rd_lit("ramp_lit", 8, 1, 0);
      rd_lit("ramp_lit", 255, 15, 15);
      rd_lit("ramp_lit", 0, 0, 0);
      check_frame("ramp");
      repeat (20) @(negedge clk);
      chk("ramp_single_start_r1", 32'(scnt1), 32'd1);
      chk("ramp_single_start_r0", 32'(scnt0), 32'd1);

      // Frame B fills while A is still owned by the core
      fill_gen(1);
      send_frame(784, 783);
      repeat (5) @(negedge clk);
      chk("b_held_sready", 32'({s_ready1, s_ready0}), 32'd0);
      chk("b_held_nostart", 32'(scnt1), 32'd1);
      check_frame("a_kept");
      s_before = scnt1;
      pulse_done();
      wait_start("b", s_before);
      shown = gen;
      check_frame("b");
      pulse_done();
      chk("b_released_busy", 32'({busy1, busy0}), 32'd0);

      // Early s_last at pixel 500
      fill_gen(1);
      s_before = scnt1;
      e_before = ecnt1;
      send_frame(501, 500);
      repeat (10) @(negedge clk);
      chk("early_err_r1", 32'(ecnt1 - e_before), 32'd1);
      chk("early_err_r0", 32'(ecnt0 - e_before), 32'd1);
      chk("early_nostart", 32'(scnt1 - s_before), 32'd0);
      chk("early_sready", 32'(s_ready1), 32'd1);
      good_frame("after_early", 1);
      check_frame("after_early");
      pulse_done();

      // Missing s_last at pixel 783
      fill_gen(1);
      s_before = scnt1;
      e_before = ecnt1;
      send_frame(784, -1);
      repeat (10) @(negedge clk);
      chk("nolast_err", 32'(ecnt1 - e_before), 32'd1);
      chk("nolast_nostart", 32'(scnt1 - s_before), 32'd0);
      good_frame("after_nolast", 1);
      check_frame("after_nolast");
      pulse_done();

      // Quantization sweep (ROUND=1 and ROUND=0 instances)
      fill_gen(1);
      for (int i = 0; i < 7; i++) gen[i] = 8'(q_in[i]);
      s_before = scnt1;
      send_frame(784, 783);
      wait_start("sweep", s_before);
      shown = gen;
      for (int i = 0; i < 7; i++) rd_lit($sformatf("sweep_in%0d", q_in[i]), i, q_r1[i], q_r0[i]);

      // Reset while busy and after 300 pixels of the next frame
      rd_addr = 10'd6;
      fill_gen(1);
      send_frame(300, -1);
      chk("pre_rst_busy", 32'({busy1, busy0}), 32'd3);
      chk("pre_rst_rdata", 32'({rd_data1, rd_data0}), 32'hFF);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_busy",  32'({busy1, busy0}), 32'd0);
      chk("async_rst_start", 32'({start1, start0}), 32'd0);
      chk("async_rst_err",   32'({frame_err1, frame_err0}), 32'd0);
      chk("async_rst_rdata", 32'({rd_data1, rd_data0}), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_sready", 32'({s_ready1, s_ready0}), 32'd3);
      s_before = scnt1;
      repeat (30) @(negedge clk);
      chk("post_rst_no_stale_start", 32'(scnt1 - s_before), 32'd0);
      good_frame("post_rst", 1);
      check_frame("post_rst");
      pulse_done();
      chk("final_busy", 32'({busy1, busy0}), 32'd0);
      chk("start_count_match", 32'(scnt0), 32'(scnt1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/image_frame_loader.md
Name: image_frame_loader

Overview:
- Upstream input stage for the MNIST inference core: accepts an 8-bit grayscale pixel stream, quantizes each pixel to unsigned 4-bit, and writes it into a double-buffered 784-entry frame store.
- Serves the core's pixel fetch port with the same 1-cycle read latency as the image ROM.
- Issues a one-cycle start pulse per complete frame and holds that frame until the core reports done, while the next frame fills the other bank.

Parameters:
- FRAME_PIXELS, 784, pixels per frame (28x28).
- ADDR_W, 10, read/write address width; must satisfy 2^ADDR_W >= FRAME_PIXELS.
- ROUND, 1, 1 = round-to-nearest with saturation, 0 = truncate.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- s_pixel  in  8  unsigned input pixel.
- s_valid  in  1  pixel valid.
- s_last  in  1  marks the final pixel of a frame; qualified by s_valid.
- s_ready  out  1  loader can accept a pixel this cycle.
- rd_addr  in  ADDR_W  pixel index from the core's controller.
- rd_data  out  4  quantized pixel at rd_addr, registered, 1-cycle latency.
- start  out  1  one-cycle pulse: a frame is ready in the read bank.
- net_done  in  1  core finished the current frame (pulse or level; rising edge used).
- frame_err  out  1  one-cycle pulse: frame discarded because of length mismatch.
- busy  out  1  read bank is owned by the core (from start until net_done).

Behaviour:
- Reset is asynchronous. All of the following clear: start, frame_err, busy, rd_data, write count, and the bank-select bit (write bank 0, read bank 1). Both banks are marked not-full. s_ready = 1 after reset.
- Quantization, ROUND=1: q = min(15, (s_pixel + 8) >> 4), computed 9 bits wide. ROUND=0: q = s_pixel[7:4]. Examples: 0->0, 7->0, 8->1, 247->15, 255->15.
- Write FSM states:
  - W_FILL: the transfer is (s_valid & s_ready). Each transfer writes q to wbank[wcnt], then wcnt++.
  - Good frame: transfer with s_last and wcnt == FRAME_PIXELS-1. Go to W_FULL.
  - Early s_last (wcnt < FRAME_PIXELS-1), or no s_last when wcnt == FRAME_PIXELS-1: frame_err pulse, wcnt <= 0, stay in W_FILL. The write bank is not swapped; its contents are don't-care.
  - W_FULL: s_ready = 0. Wait for the read side to be in R_IDLE. In the same cycle, toggle bank select, wcnt <= 0, and return to W_FILL. s_ready rises the cycle after the swap.
- Read FSM states:
  - R_IDLE: a swap occurs -> R_START.
  - R_START: start = 1 for exactly one cycle -> R_BUSY.
  - R_BUSY: busy = 1. Rising edge of net_done -> R_IDLE.
- A swap and net_done in the same cycle cannot conflict, because a swap requires R_IDLE. A net_done edge seen outside R_BUSY is ignored.
- Throughput: one pixel per cycle while filling. Minimum gap between start pulses equals the core processing time.
- Read port: rd_data <= rbank[rd_addr] every cycle, independent of the FSM state. Addresses >= FRAME_PIXELS return 0.
- The write bank and read bank are never the same physical bank. A write never corrupts the frame being read.
- s_ready is a function of registered state only: it is high in W_FILL and low in W_FULL. It has no combinational path from s_valid.
- Reset mid-frame: the partial frame is lost, no start is issued, and FSMs restart in W_FILL / R_IDLE.
- Reset during R_BUSY: busy drops immediately (asynchronously). The core is reset by the same rst.

Decomposition:
- Shared package holds:
  - the FRAME_PIXELS and PIXEL_Q_W = 4 constants (also used by the core layers);
  - the write-FSM state enum (W_FILL, W_FULL);
  - the read-FSM state enum (R_IDLE, R_START, R_BUSY);
  - the quantize function.
- One sub-module: frame_bank_ram, a simple dual-port RAM with a 4-bit x 2^ADDR_W array, one write port, and a registered read port. Instantiate it twice.
- Bank-select muxing and the FSMs live in image_frame_loader.

Test Plan:
- Single frame, pixel i = i mod 256, s_last on pixel 783:
  - start pulses exactly once, 2 cycles after the last transfer;
  - reading addr 8 yields 1, addr 255 yields 15, addr 0 yields 0 (ROUND=1).
- Back-to-back frames A and B with net_done held off:
  - B fills fully, then s_ready = 0;
  - rd_data still returns frame A values;
  - after the net_done pulse, a second start follows and reads return frame B.
- Early s_last at pixel 500:
  - frame_err pulses once and no start is issued;
  - a following good frame produces start with correct data.
- Missing s_last at pixel 783: frame_err pulses, wcnt returns to 0, and the next correct frame loads normally.
- Quantization sweep, ROUND=0 vs ROUND=1, for inputs 0, 7, 8, 15, 16, 247, 255:
  - ROUND=0 gives 0, 0, 0, 0, 1, 15, 15;
  - ROUND=1 gives 0, 0, 1, 1, 1, 15, 15.
- Reset asserted after 300 pixels and also during busy:
  - start, busy, frame_err and rd_data go to 0 asynchronously, and s_ready = 1 after release;
  - a subsequent full frame starts correctly, and no stale start appears.
